// File: rtl/windowed_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : windowed_acc_pkg
// Purpose  : Shared types, constants and helper functions for the
//            windowed accumulator. Saturation build option:
//            WINDOWED_ACC_SATURATE_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package windowed_acc_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_t;

  // Extend a data_w-bit sample held in the low bits of d to the full 64 bits,
  // sign-extending when sgn is set and zero-extending otherwise.
  function automatic logic [63:0] ext_sample(input logic [63:0] d, input int data_w, input bit sgn);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 64; i++) begin
      if (i >= data_w) begin
        r[i] = sgn ? d[data_w-1] : 1'b0;
      end
    end
    return r;
  endfunction

  // Largest representable sum: 2**acc_w-1 unsigned, 2**(acc_w-1)-1 signed.
  function automatic logic [63:0] sat_max(input int acc_w, input bit sgn);
    logic [63:0] one;
    one = 64'd1;
    return sgn ? ((one << (acc_w - 1)) - one) : ((one << acc_w) - one);
  endfunction

  // Smallest representable sum as a bit pattern: 0 unsigned, sign bit only signed.
  function automatic logic [63:0] sat_min(input int acc_w, input bit sgn);
    logic [63:0] one;
    one = 64'd1;
    return sgn ? (one << (acc_w - 1)) : 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_add_sat.sv
`default_nettype none
// ============================================================================
// Module   : acc_add_sat
// Purpose  : Combinational ACC_W adder with overflow detect; wraps modulo
//            2**ACC_W, or clamps when WINDOWED_ACC_SATURATE_EN is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module acc_add_sat
  import windowed_acc_pkg::*;
#(
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] w_raw;

  generate
    if (SIGNED != 0) begin : g_signed
      // Signed overflow: like-signed operands producing an opposite-signed result.
      assign w_raw = a + b;
      assign ovf   = (a[ACC_W-1] == b[ACC_W-1]) && (w_raw[ACC_W-1] != a[ACC_W-1]);
    end else begin : g_unsigned
      // Unsigned overflow: carry out of the top bit.
      logic [ACC_W:0] w_full;
      assign w_full = {1'b0, a} + {1'b0, b};
      assign w_raw  = w_full[ACC_W-1:0];
      assign ovf    = w_full[ACC_W];
    end
  endgenerate

`ifdef WINDOWED_ACC_SATURATE_EN
  // Signed overflow can only go negative when both operands were negative.
  assign sum = !ovf ? w_raw :
               ((SIGNED != 0) && a[ACC_W-1]) ? ACC_W'(sat_min(ACC_W, SIGNED != 0))
                                             : ACC_W'(sat_max(ACC_W, SIGNED != 0));
`else
  assign sum = w_raw;
`endif

endmodule
`default_nettype wire

// File: rtl/windowed_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : windowed_accumulator
// Purpose  : Running-sum accumulator with valid/ready handshakes, sticky
//            overflow, synchronous clear and a windowed dump mode emitting the
//            sum of every WIN_LEN accepted samples. Optional clamping on
//            overflow via WINDOWED_ACC_SATURATE_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module windowed_accumulator
  import windowed_acc_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int SIGNED  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [ACC_W-1:0]  acc_q,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_ovf;

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_accept;
  logic             w_last;

  assign w_ext = ACC_W'(ext_sample(64'(in_data), DATA_W, SIGNED != 0));

  acc_add_sat #(
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_add (
    .a  (r_acc),
    .b  (w_ext),
    .sum(w_sum),
    .ovf(w_add_ovf)
  );

  // A count at or past the window end (possible after a 0->1 mode switch) closes the window.
  assign w_accept = in_valid && in_ready;
  assign w_last   = mode && (r_cnt >= c_last);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and input-side handshake; clear blocks acceptance but never moves the FSM.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = !clear;
        if (w_accept && w_last) begin
          w_next_state = DUMP;
        end
      end
      DUMP: begin
        if (out_ready) begin
          w_next_state = ACCUM;
        end
      end
      default: w_next_state = ACCUM;
    endcase
  end

  // Running sum, sample counter and sticky overflow; clear outranks a sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_out_data <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= r_ovf | w_add_ovf;
      if (w_last) begin
        r_out_data <= w_sum;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
      end
    end
  end

  // Result-valid flag: raised at window close, dropped when the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
    end else if ((r_state == DUMP) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign acc_q      = r_acc;
  assign sample_cnt = r_cnt;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
